// File: rtl/spi_tx_byte_packer.sv
// spi_tx_byte_packer
//   Packs a byte stream into 64-bit words for the 8-lane SPI TX interface.
//   The first byte of a word lands in [7:0] and the eighth in [63:56]. A short final
//   word has its unused lanes filled with PAD_BYTE and is flagged by a keep mask and
//   the frame byte length. A one-word accumulator feeds one output register, so bytes
//   can be accepted every cycle while downstream keeps up.
//
// Ports
//   pk_iclk    in   system clock
//   pk_irst_n  in   asynchronous active-low reset
//   pk_ival    in   input byte valid
//   pk_idata   in   input byte
//   pk_ilast   in   input byte is the last byte of its frame (qualified by pk_ival)
//   pk_oready  out  a byte is accepted when pk_ival & pk_oready
//   pk_oval    out  output word valid
//   pk_odata   out  output word, byte k in [8k+7:8k]
//   pk_olast   out  output word is the last word of its frame
//   pk_okeep   out  valid-byte mask of the output word
//   pk_olen    out  frame byte count, meaningful when pk_oval & pk_olast
//   pk_iready  in   downstream takes the word when pk_oval & pk_iready
module spi_tx_byte_packer #(
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int unsigned LEN_W    = 16
) (
  input  logic             pk_iclk,
  input  logic             pk_irst_n,
  input  logic             pk_ival,
  input  logic [7:0]       pk_idata,
  input  logic             pk_ilast,
  output logic             pk_oready,
  output logic             pk_oval,
  output logic [63:0]      pk_odata,
  output logic             pk_olast,
  output logic [7:0]       pk_okeep,
  output logic [LEN_W-1:0] pk_olen,
  input  logic             pk_iready
);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e             state_q, state_d;
  logic [63:0]        acc_q, acc_d;
  logic [2:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               hold_last_q, hold_last_d;

  logic               oval_q, oval_d;
  logic [63:0]        odata_q, odata_d;
  logic               olast_q, olast_d;
  logic [7:0]         okeep_q, okeep_d;
  logic [LEN_W-1:0]   olen_q, olen_d;

  logic               accept;
  logic               complete;
  logic               out_free;
  logic               load;
  logic [63:0]        acc_wr;
  logic [LEN_W-1:0]   cnt_inc;
  logic [63:0]        word_src;
  logic               word_last;
  logic [LEN_W-1:0]   word_cnt;
  logic [63:0]        word_data;
  logic [7:0]         word_keep;

  // Handshake and accumulator update for the byte on the input this cycle.
  always_comb begin
    accept   = pk_ival & (state_q == StFill);
    complete = accept & ((idx_q == 3'd7) | pk_ilast);
    out_free = ~oval_q | pk_iready;

    acc_wr = acc_q;
    acc_wr[{idx_q, 3'b000} +: 8] = pk_idata;

    cnt_inc = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  // Candidate output word: the parked word in HOLD, otherwise the word being completed
  // (which must include the byte arriving right now).
  always_comb begin
    if (state_q == StHold) begin
      word_src  = acc_q;
      word_last = hold_last_q;
      word_cnt  = cnt_q;
    end else begin
      word_src  = acc_wr;
      word_last = pk_ilast;
      word_cnt  = cnt_inc;
    end

    word_data = '0;
    word_keep = '0;
    // Lanes past idx may hold bytes of an earlier word, so they are always padded.
    for (int k = 0; k < 8; k++) begin
      if (k <= int'(idx_q)) begin
        word_data[8*k +: 8] = word_src[8*k +: 8];
        word_keep[k]        = 1'b1;
      end else begin
        word_data[8*k +: 8] = PAD_BYTE;
      end
    end
  end

  // Accumulator FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    hold_last_d = hold_last_q;
    load        = 1'b0;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          acc_d = acc_wr;
          if (complete) begin
            if (out_free) begin
              load  = 1'b1;
              idx_d = 3'd0;
              cnt_d = pk_ilast ? '0 : cnt_inc;
            end else begin
              // Park the word; idx stays on the completing lane to size the keep mask.
              state_d     = StHold;
              hold_last_d = pk_ilast;
              cnt_d       = cnt_inc;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = cnt_inc;
          end
        end
      end
      StHold: begin
        if (out_free) begin
          load    = 1'b1;
          state_d = StFill;
          idx_d   = 3'd0;
          cnt_d   = hold_last_q ? '0 : cnt_q;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Output register.
  always_comb begin
    oval_d  = oval_q;
    odata_d = odata_q;
    olast_d = olast_q;
    okeep_d = okeep_q;
    olen_d  = olen_q;

    if (load) begin
      oval_d  = 1'b1;
      odata_d = word_data;
      olast_d = word_last;
      okeep_d = word_keep;
      if (word_last) begin
        olen_d = word_cnt;
      end
    end else if (oval_q && pk_iready) begin
      oval_d = 1'b0;
    end
  end

  always_ff @(posedge pk_iclk or negedge pk_irst_n) begin
    if (!pk_irst_n) begin
      state_q     <= StFill;
      acc_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      hold_last_q <= 1'b0;
      oval_q      <= 1'b0;
      odata_q     <= '0;
      olast_q     <= 1'b0;
      okeep_q     <= '0;
      olen_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      hold_last_q <= hold_last_d;
      oval_q      <= oval_d;
      odata_q     <= odata_d;
      olast_q     <= olast_d;
      okeep_q     <= okeep_d;
      olen_q      <= olen_d;
    end
  end

  assign pk_oready = (state_q == StFill);
  assign pk_oval   = oval_q;
  assign pk_odata  = odata_q;
  assign pk_olast  = olast_q;
  assign pk_okeep  = okeep_q;
  assign pk_olen   = olen_q;

endmodule

// File: tb/tb_spi_tx_byte_packer.sv
// Bench for spi_tx_byte_packer: frames are turned into expected words and queued
// as they are driven; a negedge monitor pops and compares on every word transfer
// and checks that a stalled word stays stable.
module tb_spi_tx_byte_packer;

  localparam int unsigned LEN_W = 16;

  typedef struct {
    logic [63:0]      data;
    logic [7:0]       keep;
    logic             last;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             ival;
  logic [7:0]       idata;
  logic             ilast;
  logic             oready;
  logic             oval;
  logic [63:0]      odata;
  logic             olast;
  logic [7:0]       okeep;
  logic [LEN_W-1:0] olen;
  logic             iready;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt = 0;
  bit rand_rdy = 0;

  exp_t       sb_q[$];
  logic [7:0] frame_q[$];

  // Stall snapshot used by the monitor.
  logic             stall_q = 1'b0;
  logic [63:0]      snap_data;
  logic [7:0]       snap_keep;
  logic             snap_last;
  logic [LEN_W-1:0] snap_len;

  spi_tx_byte_packer #(
    .PAD_BYTE (8'h00),
    .LEN_W    (LEN_W)
  ) dut (
    .pk_iclk   (clk),
    .pk_irst_n (rst_n),
    .pk_ival   (ival),
    .pk_idata  (idata),
    .pk_ilast  (ilast),
    .pk_oready (oready),
    .pk_oval   (oval),
    .pk_odata  (odata),
    .pk_olast  (olast),
    .pk_okeep  (okeep),
    .pk_olen   (olen),
    .pk_iready (iready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: inputs change at posedge+1, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (stall_q) begin
      check_eq("stall_oval", oval, 1);
      check_eq("stall_data", odata, snap_data);
      check_eq("stall_keep", okeep, snap_keep);
      check_eq("stall_last", olast, snap_last);
      check_eq("stall_len", olen, snap_len);
    end
    if (oval && iready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_word", odata, 64'hx);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("word_data", odata, e.data);
        check_eq("word_keep", okeep, e.keep);
        check_eq("word_last", olast, e.last);
        if (e.last) check_eq("word_len", olen, e.len);
      end
    end
    stall_q   <= oval && !iready;
    snap_data <= odata;
    snap_keep <= okeep;
    snap_last <= olast;
    snap_len  <= olen;
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      iready = 1'($urandom_range(0, 1));
    end
  end

  task automatic build_seq(input logic [7:0] start, input int n);
    frame_q = {};
    for (int i = 0; i < n; i++) frame_q.push_back(start + 8'(i));
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic l);
    int t;
    t = 0;
    ival  = 1'b1;
    idata = b;
    ilast = l;
    while (!oready && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
      stall_cnt++;
    end
    if (t >= 1000) check_eq("oready_timeout", oready, 1);
    @(posedge clk);
    #1;
  endtask

  // Queue the expected words of frame_q, then drive its bytes back to back.
  task automatic send_frame();
    int n;
    int nw;
    n  = frame_q.size();
    nw = (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      exp_t e;
      e.data = '0;
      e.keep = '0;
      for (int k = 0; k < 8; k++) begin
        if (w * 8 + k < n) begin
          e.data[8*k +: 8] = frame_q[w*8 + k];
          e.keep[k]        = 1'b1;
        end
      end
      e.last = (w == nw - 1);
      e.len  = LEN_W'(n);
      sb_q.push_back(e);
    end
    for (int i = 0; i < n; i++) send_byte(frame_q[i], i == n - 1);
    ival  = 1'b0;
    ilast = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq(tag, 64'(sb_q.size()), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_oval"}, oval, 0);
    check_eq({tag, "_odata"}, odata, 0);
    check_eq({tag, "_olast"}, olast, 0);
    check_eq({tag, "_okeep"}, okeep, 0);
    check_eq({tag, "_olen"}, olen, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    ival   = 1'b0;
    idata  = 8'h00;
    ilast  = 1'b0;
    iready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_oready", oready, 1);

    // T1: one full word, last on the eighth byte.
    build_seq(8'h01, 8);
    send_frame();
    check_eq("t1_lat_oval", oval, 1);
    check_eq("t1_data", odata, 64'h0807060504030201);
    check_eq("t1_keep", okeep, 8'hFF);
    check_eq("t1_len", olen, 8);
    wait_drain("t1_drain");

    // T2: short frame, padded lanes.
    frame_q = {8'hAA, 8'hBB, 8'hCC};
    send_frame();
    check_eq("t2_data", odata, 64'h0000000000CCBBAA);
    check_eq("t2_keep", okeep, 8'h07);
    check_eq("t2_len", olen, 3);
    wait_drain("t2_drain");

    // T3: stray ilast without ival must be ignored; 17 bytes make 3 words.
    ilast = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ilast = 1'b0;
    stall_cnt = 0;
    build_seq(8'h00, 17);
    send_frame();
    check_eq("t3_no_stall", stall_cnt, 0);
    check_eq("t3_w3_keep", okeep, 8'h01);
    check_eq("t3_w3_byte", odata[7:0], 8'h10);
    check_eq("t3_len", olen, 17);
    wait_drain("t3_drain");

    // T4: downstream stalled across two words.
    iready = 1'b0;
    build_seq(8'h40, 16);
    send_frame();
    check_eq("t4_hold_oready", oready, 0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t4_still_hold", oready, 0);
    check_eq("t4_w1_low", odata[7:0], 8'h40);
    iready = 1'b1;
    wait_drain("t4_drain");
    check_eq("t4_oready_back", oready, 1);

    // T5: 1-byte frame directly followed by a 2-byte frame.
    frame_q = {8'h5A};
    send_frame();
    frame_q = {8'h01, 8'h02};
    send_frame();
    wait_drain("t5_drain");

    // T6: reset mid-frame discards the partial word and count.
    build_seq(8'hE0, 5);
    for (int i = 0; i < 5; i++) send_byte(frame_q[i], 1'b0);
    ival  = 1'b0;
    rst_n = 1'b0;
    #2;
    check_reset_state("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_oready", oready, 1);
    build_seq(8'h11, 8);
    send_frame();
    check_eq("t6_data", odata, 64'h1817161514131211);
    check_eq("t6_len", olen, 8);
    wait_drain("t6_drain");

    // T7: random backpressure over frames of random length.
    rand_rdy = 1;
    for (int f = 0; f < 6; f++) begin
      build_seq(8'($urandom), int'($urandom_range(1, 20)));
      send_frame();
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    iready = 1'b1;
    wait_drain("t7_drain");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
